// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared state encoding and constants for the FIR sequencer.
package fir_seq_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, CLEAR, ACCUM, DRAIN, OUTPUT} state_t;
  localparam int DRAIN_CYCLES = 1;
  localparam int OVR_CNT_W = 8;
endpackage

// File: rtl/tap_counter.sv
// tap_counter: tap index counter with clear, enable and terminal-count flag.
module tap_counter #(
  parameter int TAPS = 16,
  parameter int SEL_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);
  assign tc = cnt == SEL_W'(TAPS - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + SEL_W'(1);
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: Moore sequencer driving FIR datapath enables per sample strobe.
// Define OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module fir_seq_ctrl
  import fir_seq_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int SEL_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_strobe,
  input  logic             clr_overrun,
  output logic             in_en,
  output logic             shift_en,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [SEL_W-1:0] tap_sel,
  output logic             out_en,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] overrun_cnt
`endif
);
  state_t state, state_nx;
  logic tc, cnt_clr, cnt_en, ovr_hit;
  // clearing on tc returns tap_sel to 0 as the sequence leaves ACCUM
  assign cnt_en  = state == ACCUM;
  assign cnt_clr = !cnt_en || tc;
  assign ovr_hit = sample_strobe && busy;
  tap_counter #(.TAPS(TAPS), .SEL_W(SEL_W)) u_tap_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (tap_sel),
    .tc   (tc)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= state == OUTPUT;
      overrun   <= ovr_hit || (overrun && !clr_overrun);
    end
  always_comb begin
    state_nx = state;
    in_en    = state == CAPTURE;
    shift_en = state == CAPTURE;
    mac_clr  = state == CLEAR;
    mac_en   = state == ACCUM;
    out_en   = state == OUTPUT;
    busy     = state != IDLE;
    case (state)
      IDLE:    state_nx = sample_strobe ? CAPTURE : IDLE;
      CAPTURE: state_nx = CLEAR;
      CLEAR:   state_nx = ACCUM;
      ACCUM:   state_nx = tc ? DRAIN : ACCUM;
      DRAIN:   state_nx = OUTPUT;
      OUTPUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
`ifdef OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun_cnt <= '0;
    else if (ovr_hit) overrun_cnt <= clr_overrun ? OVR_CNT_W'(1) : (&overrun_cnt ? overrun_cnt : overrun_cnt + OVR_CNT_W'(1));
    else if (clr_overrun) overrun_cnt <= '0;
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: checks TAPS=16 and TAPS=2 sequencers against a timing-table model.
// Counter checks apply when OVERRUN_CNT_EN is defined.
module tb_fir_seq_ctrl;
  logic clk = 0, reset = 0, strobe = 0, clr = 0;
  logic in16, sh16, mc16, me16, oe16, ov16, bz16, or16;
  logic in2, sh2, mc2, me2, oe2, ov2, bz2, or2;
  logic [3:0] ts16;
  logic [0:0] ts2;
  logic [7:0] cnt16, cnt2;
  int a16 = 1000, a2 = 1000, c16 = 0, c2 = 0;
  logic o16 = 0, o2 = 0;
  int checks = 0, passed = 0;
  logic [19:0] obs16, obs2, exp16, exp2;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.TAPS(16), .SEL_W(4)) dut16 (
    .clk(clk), .reset(reset), .sample_strobe(strobe), .clr_overrun(clr),
    .in_en(in16), .shift_en(sh16), .mac_clr(mc16), .mac_en(me16), .tap_sel(ts16),
    .out_en(oe16), .out_valid(ov16), .busy(bz16), .overrun(or16)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt(cnt16)
`endif
  );
  fir_seq_ctrl #(.TAPS(2), .SEL_W(1)) dut2 (
    .clk(clk), .reset(reset), .sample_strobe(strobe), .clr_overrun(clr),
    .in_en(in2), .shift_en(sh2), .mac_clr(mc2), .mac_en(me2), .tap_sel(ts2),
    .out_en(oe2), .out_valid(ov2), .busy(bz2), .overrun(or2)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt(cnt2)
`endif
  );
`ifndef OVERRUN_CNT_EN
  assign cnt16 = '0;
  assign cnt2  = '0;
`endif

  assign obs16 = {in16, sh16, mc16, me16, ts16, oe16, ov16, bz16, or16, cnt16};
  assign obs2  = {in2, sh2, mc2, me2, 3'b000, ts2, oe2, ov2, bz2, or2, cnt2};

  // Expected outputs from the timing table: a = cycles since the accepted strobe
  function automatic logic [19:0] expv(int a, int t, logic o, int c);
    logic [3:0] ts;
    logic [7:0] cc;
    ts = (a >= 3 && a <= t + 2) ? 4'(a - 3) : 4'd0;
`ifdef OVERRUN_CNT_EN
    cc = 8'(c);
`else
    cc = 8'd0;
`endif
    return {a == 1, a == 1, a == 2, a >= 3 && a <= t + 2, ts, a == t + 4, a == t + 5,
            a >= 1 && a <= t + 4, o, cc};
  endfunction

  task automatic upd(input int t, inout int a, inout logic o, inout int c);
    if (strobe && a >= 1 && a <= t + 4) begin
      o = 1;
      c = clr ? 1 : (c >= 255 ? 255 : c + 1);
      a = a + 1;
    end else begin
      if (clr) begin o = 0; c = 0; end
      a = strobe ? 1 : (a >= 1000 ? 1000 : a + 1);
    end
  endtask

  task automatic model_reset();
    a16 = 1000; a2 = 1000; o16 = 0; o2 = 0; c16 = 0; c2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      upd(16, a16, o16, c16);
      upd(2, a2, o2, c2);
    end
    #1;
    exp16 = expv(a16, 16, o16, c16);
    exp2  = expv(a2, 2, o2, c2);
  endtask

  task automatic test_reset();
    reset = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (obs16 !== 20'd0) $display("FAIL reset dut16 got %h want 0", obs16); else passed++;
      if (obs2 !== 20'd0) $display("FAIL reset dut2 got %h want 0", obs2); else passed++;
      tick();
    end
    reset = 1;
  endtask

  task automatic test_single();
    strobe = 1;
    for (int i = 0; i < 26; i++) begin
      tick();
      strobe = 0;
      checks += 2;
      if (obs16 !== exp16) $display("FAIL single cyc=%0d dut16 got %h want %h", i + 1, obs16, exp16); else passed++;
      if (obs2 !== exp2) $display("FAIL single cyc=%0d dut2 got %h want %h", i + 1, obs2, exp2); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 46; i++) begin
      strobe = (i == 0 || i == 21);
      tick();
      checks += 2;
      if (obs16 !== exp16) $display("FAIL b2b cyc=%0d dut16 got %h want %h", i + 1, obs16, exp16); else passed++;
      if (obs2 !== exp2) $display("FAIL b2b cyc=%0d dut2 got %h want %h", i + 1, obs2, exp2); else passed++;
    end
    strobe = 0;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 30; i++) begin
      strobe = (i == 0 || i == 10);
      clr = (i == 28);
      tick();
      checks += 2;
      if (obs16 !== exp16) $display("FAIL overrun cyc=%0d dut16 got %h want %h", i + 1, obs16, exp16); else passed++;
      if (obs2 !== exp2) $display("FAIL overrun cyc=%0d dut2 got %h want %h", i + 1, obs2, exp2); else passed++;
    end
    strobe = 0; clr = 0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 330; i++) begin
      strobe = i < 300 || i == 322;
      clr = (i == 310 || i == 322);
      tick();
      checks += 2;
      if (obs16 !== exp16) $display("FAIL saturate cyc=%0d dut16 got %h want %h", i + 1, obs16, exp16); else passed++;
      if (obs2 !== exp2) $display("FAIL saturate cyc=%0d dut2 got %h want %h", i + 1, obs2, exp2); else passed++;
    end
    strobe = 0; clr = 0;
    repeat (25) tick();
  endtask

  task automatic test_reset_mid();
    strobe = 1;
    tick();
    strobe = 0;
    for (int i = 0; i < 40 && a16 != 10; i++) tick();
    checks++;
    if (ts16 !== 4'd7) $display("FAIL mid_tap got %0d want 7", ts16); else passed++;
    reset = 0;
    #1;
    model_reset();
    checks++;
    if (obs16 !== 20'd0) $display("FAIL mid_async got %h want 0", obs16); else passed++;
    tick();
    reset = 1;
    for (int i = 0; i < 55; i++) begin
      strobe = (i == 25);
      tick();
      checks += 2;
      if (obs16 !== exp16) $display("FAIL mid cyc=%0d dut16 got %h want %h", i + 1, obs16, exp16); else passed++;
      if (obs2 !== exp2) $display("FAIL mid cyc=%0d dut2 got %h want %h", i + 1, obs2, exp2); else passed++;
    end
    strobe = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      strobe = $urandom_range(0, 9) == 0;
      clr = $urandom_range(0, 11) == 0;
      tick();
      checks += 2;
      if (obs16 !== exp16) $display("FAIL random cyc=%0d dut16 got %h want %h", i + 1, obs16, exp16); else passed++;
      if (obs2 !== exp2) $display("FAIL random cyc=%0d dut2 got %h want %h", i + 1, obs2, exp2); else passed++;
    end
    strobe = 0; clr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
